// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the iterative shift-add multiplier.
//   - state_t   : FSM encoding (IDLE -> BUSY -> DONE -> IDLE)
//   - DEF_WIDTH : default operand width, PWIDTH the matching product width
//   - abs_w     : conditional two's-complement negate of an operand
//   - neg_2w    : conditional two's-complement negate of a product
//   The helpers work on MAX_WIDTH / MAX_PWIDTH vectors. Callers zero-extend a
//   narrower value, pass its sign separately and keep the low bits of the
//   result: negation modulo 2^MAX keeps the low bits equal to negation
//   modulo 2^WIDTH, so one helper serves every operand width up to MAX_WIDTH.
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int DEF_WIDTH   = 64;
    localparam int PWIDTH      = 2 * DEF_WIDTH;
    localparam int MAX_WIDTH   = 128;
    localparam int MAX_PWIDTH  = 2 * MAX_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of an operand whose sign is given by neg. The most negative
    // value maps onto itself, which read as unsigned is exactly 2^(WIDTH-1).
    function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] x,
                                                   input logic                 neg);
        return neg ? (~x) + MAX_WIDTH'(1) : x;
    endfunction

    // Apply the result sign to an unsigned product.
    function automatic logic [MAX_PWIDTH-1:0] neg_2w(input logic [MAX_PWIDTH-1:0] x,
                                                     input logic                  neg);
        return neg ? (~x) + MAX_PWIDTH'(1) : x;
    endfunction

endpackage : mult_pkg

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Iterative radix-2 shift-add multiplier. One operation in flight; the
//   product appears exactly WIDTH+1 cycles after the accept edge, regardless
//   of operand values.
//
//   Ports
//     CLK        in   1        clock, all state updates on posedge
//     RESET_N    in   1        asynchronous active-low reset
//     in_valid   in   1        operands a, b valid this cycle
//     in_ready   out  1        high in IDLE only
//     a          in   WIDTH    multiplicand (sampled at accept only)
//     b          in   WIDTH    multiplier   (sampled at accept only)
//     out_valid  out  1        product valid, held until accepted
//     out_ready  in   1        consumer takes product
//     product    out  2*WIDTH  full-precision a*b
//
//   Parameters
//     WIDTH   operand width (up to mult_pkg::MAX_WIDTH)
//     SIGNED  0 = unsigned, 1 = two's-complement operands and product
// ---------------------------------------------------------------------------
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter bit SIGNED = 1'b0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;    // multiplicand magnitude
    logic [WIDTH-1:0] mplier_q,  mplier_d;   // multiplier magnitude, shifted right each step
    logic [PW:0]      acc_q,     acc_d;      // accumulator with carry bit on top
    logic             sign_q,    sign_d;     // sign to apply to the final product
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [PW-1:0]    product_q, product_d;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   upper_sum;

    assign a_neg = SIGNED & a[WIDTH-1];
    assign b_neg = SIGNED & b[WIDTH-1];

    // Carry bit plus upper half, plus the multiplicand when the current
    // multiplier bit is set. The carry bit is always clear before the add
    // because the previous step shifted it down, so WIDTH+1 bits never overflow.
    assign upper_sum = acc_q[PW:WIDTH] + {1'b0, (mplier_q[0] ? mcand_q : '0)};

    // NOTE: every variable written in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d  = WIDTH'(abs_w(MAX_WIDTH'(a), a_neg));
                    mplier_d = WIDTH'(abs_w(MAX_WIDTH'(b), b_neg));
                    sign_d   = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end

            BUSY: begin
                if (cnt_q == CW'(WIDTH)) begin
                    // All multiplier bits consumed: the low PW bits hold the
                    // unsigned product, apply the sign on the way out.
                    product_d = PW'(neg_2w(MAX_PWIDTH'(acc_q[PW-1:0]), sign_q));
                    state_d   = DONE;
                end else begin
                    acc_d    = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    // The datapath registers are reset too: product must read zero after reset
    // and a reset mid-operation has to discard the partial result.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//   Bench for seq_multiplier at WIDTH=64 with one unsigned and one signed
//   instance side by side. Directed table of corner products, hand-written
//   backpressure and mid-operation reset sequences, then random operations
//   on both instances compared against a plain-arithmetic reference.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W       = 64;
    localparam int LATENCY = W + 1;
    localparam int BOUND   = 300;

    logic         CLK;
    logic         RESET_N;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] a_in      [2];
    logic [W-1:0] b_in      [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [2*W-1:0] product_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0 is unsigned, instance 1 is signed.
    seq_multiplier #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .a         (a_in[0]),
        .b         (b_in[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .product   (product_o[0])
    );

    seq_multiplier #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .a         (a_in[1]),
        .b         (b_in[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .product   (product_o[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string          name;
        int             s;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: sign- or zero-extend to 2*W bits and multiply modulo 2^(2*W).
    function automatic logic [2*W-1:0] ref_mul(input int s, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        ex = (s == 1) ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = (s == 1) ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return '1;
            3:       return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic start_op(input int s, input logic [W-1:0] av, input logic [W-1:0] bv);
        int k = 0;
        while (!in_ready[s] && k < BOUND) begin
            @(negedge CLK);
            k++;
        end
        if (!in_ready[s]) check("start_timeout", 128'(in_ready[s]), 128'(1));
        in_valid[s] = 1'b1;
        a_in[s]     = av;
        b_in[s]     = bv;
        @(posedge CLK);
        @(negedge CLK);
        in_valid[s] = 1'b0;
        a_in[s]     = {$urandom, $urandom};
        b_in[s]     = {$urandom, $urandom};
    endtask

    // Counts negedges until out_valid; returns the count and the product.
    task automatic wait_valid(input int s, output int lat, output logic [2*W-1:0] p);
        int k = 0;
        while (!out_valid[s] && k < BOUND) begin
            @(negedge CLK);
            k++;
        end
        lat = k;
        p   = product_o[s];
    endtask

    task automatic finish_op(input int s);
        out_ready[s] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        out_ready[s] = 1'b0;
    endtask

    task automatic rand_loop(input int s, input int n_ops);
        logic [W-1:0]   av;
        logic [W-1:0]   bv;
        logic [2*W-1:0] p;
        int             lat;
        for (int i = 0; i < n_ops; i++) begin
            av = pick();
            bv = pick();
            start_op(s, av, bv);
            wait_valid(s, lat, p);
            check((s == 1) ? "rand_prod_signed" : "rand_prod_unsigned", p, ref_mul(s, av, bv));
            check("rand_latency", 128'(lat), 128'(LATENCY));
            finish_op(s);
        end
    endtask

    vec_t           vecs [10];
    int             lat;
    logic [2*W-1:0] p;

    initial begin
        vecs[0] = '{"u_3x5",       0, 64'd3, 64'd5, 128'd15};
        vecs[1] = '{"u_max_x_max", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{"u_zero_a",    0, 64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0};
        vecs[3] = '{"u_2p63_x_2",  0, 64'h8000_0000_0000_0000, 64'd2,
                    128'h0000_0000_0000_0001_0000_0000_0000_0000};
        vecs[4] = '{"s_m3_x_7",    1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB};
        vecs[5] = '{"s_m1_x_m1",   1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};
        vecs[6] = '{"s_min_x_min", 1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[7] = '{"s_min_x_1",   1, 64'h8000_0000_0000_0000, 64'd1,
                    128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
        vecs[8] = '{"s_min_x_m1",  1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'h0000_0000_0000_0000_8000_0000_0000_0000};
        vecs[9] = '{"s_zero_x_m5", 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 128'd0};

        RESET_N = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b0;
            a_in[s]      = '0;
            b_in[s]      = '0;
        end

        // Reset state
        repeat (3) @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            check("reset_in_ready",  128'(in_ready[s]),  128'(1));
            check("reset_out_valid", 128'(out_valid[s]), 128'(0));
            check("reset_product",   product_o[s],       128'(0));
        end
        RESET_N = 1'b1;
        @(negedge CLK);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_valid(vecs[i].s, lat, p);
            check(vecs[i].name, p, vecs[i].exp);
            check("table_latency", 128'(lat), 128'(LATENCY));
            finish_op(vecs[i].s);
            check("table_idle_in_ready",  128'(in_ready[vecs[i].s]),  128'(1));
            check("table_idle_out_valid", 128'(out_valid[vecs[i].s]), 128'(0));
        end

        // Backpressure: hold the result for 10 cycles while poking in_valid
        start_op(0, 64'd11, 64'd13);
        wait_valid(0, lat, p);
        check("bp_latency", 128'(lat), 128'(LATENCY));
        for (int c = 0; c < 10; c++) begin
            check("bp_out_valid", 128'(out_valid[0]), 128'(1));
            check("bp_product",   product_o[0],       128'd143);
            check("bp_in_ready",  128'(in_ready[0]),  128'(0));
            in_valid[0] = c[0];
            a_in[0]     = {$urandom, $urandom};
            b_in[0]     = {$urandom, $urandom};
            @(negedge CLK);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_release_in_ready",  128'(in_ready[0]),  128'(1));
        check("bp_release_out_valid", 128'(out_valid[0]), 128'(0));
        @(negedge CLK);
        out_ready[0] = 1'b0;
        repeat (3) @(negedge CLK);
        check("bp_no_queued_op", 128'({in_ready[0], out_valid[0]}), 128'(2'b10));

        // Reset in the middle of an operation
        start_op(0, 64'hDEAD_BEEF_0123_4567, 64'hFEED_FACE_89AB_CDEF);
        repeat (29) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid[0]), 128'(0));
        check("rst_mid_in_ready",  128'(in_ready[0]),  128'(1));
        check("rst_mid_product",   product_o[0],       128'(0));
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        start_op(0, 64'd2, 64'd9);
        wait_valid(0, lat, p);
        check("rst_after_product", p, 128'd18);
        check("rst_after_latency", 128'(lat), 128'(LATENCY));
        finish_op(0);

        // Random back-to-back operations on both instances
        fork
            rand_loop(0, 500);
            rand_loop(1, 500);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_multiplier
